playback_sequencer: RTL and testbench

Reads back the 16-entry note memory that the note-entry path writes, one slot per beat, and turns each stored note into a square-wave audio output. It drives `note_counter` and `ld_play` into the datapath, which addresses memory and returns the selected note's frequency word on `freq_out`. This block consumes that word. It sits beside the input FSM in the top level and owns the audio pin.

---
 rtl/music_pkg.sv | 19 +
 rtl/playback_sequencer_if.sv | 25 ++
 rtl/tone_gen.sv | 27 ++
 rtl/playback_sequencer.sv | 114 +++++++++++
 tb/tb_playback_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared types and sizing constants for the note memory playback and entry paths.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        TONE   = 2'd2,
        GAP    = 2'd3
    } seq_state_t;

    localparam int unsigned NUM_SLOTS            = 16;
    localparam int unsigned SLOT_W               = $clog2(NUM_SLOTS);
    localparam int unsigned FREQ_W               = 32;
    localparam int unsigned CNT_W                = 32;
    localparam int unsigned DEFAULT_BEAT_CYCLES  = 12_500_000;
    localparam int unsigned DEFAULT_GAP_CYCLES   = 1_250_000;
    localparam int unsigned DEFAULT_READ_LAT     = 3;

endpackage

// File: rtl/playback_sequencer_if.sv
// Control, memory-read and audio signals between the playback sequencer and its neighbours.
interface playback_sequencer_if;
    import music_pkg::*;

    logic              start;
    logic              stop;
    logic              loop_en;
    logic [FREQ_W-1:0] freq_in;
    logic [SLOT_W-1:0] note_counter;
    logic              ld_play;
    logic              playing;
    logic              step_done;
    logic              audio_out;

    modport master (
        output start, stop, loop_en, freq_in,
        input  note_counter, ld_play, playing, step_done, audio_out
    );

    modport slave (
        input  start, stop, loop_en, freq_in,
        output note_counter, ld_play, playing, step_done, audio_out
    );

endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: toggles wave every half_period cycles while enabled.
module tone_gen
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [FREQ_W-1:0] half_period,
    output logic              wave
);

    logic [FREQ_W-1:0] cnt;

    // Disabling clears both counter and output so every note starts low at phase 0.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half_period - FREQ_W'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt  <= cnt + FREQ_W'(1);
        end
    end

endmodule

// File: rtl/playback_sequencer.sv
// Steps through the note memory one slot per beat and plays each note as a square wave.
module playback_sequencer
    import music_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = DEFAULT_BEAT_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int unsigned READ_LAT    = DEFAULT_READ_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    playback_sequencer_if.slave  bus
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    seq_state_t        state, state_d;
    logic [CNT_W-1:0]  phase, phase_d;
    logic [SLOT_W-1:0] slot, slot_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              playing_q, playing_d;
    logic              step_done_q, step_done_d;
    logic              tone_en_c;
    logic              audio_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            slot        <= '0;
            freq_q      <= '0;
            playing_q   <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state       <= state_d;
            phase       <= phase_d;
            slot        <= slot_d;
            freq_q      <= freq_d;
            playing_q   <= playing_d;
            step_done_q <= step_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        phase_d     = (phase != '0) ? phase - CNT_W'(1) : phase;
        slot_d      = slot;
        freq_d      = freq_q;

        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = SETTLE;
                    slot_d  = '0;
                    phase_d = CNT_W'(READ_LAT - 1);
                end
            end
            SETTLE: begin
                if (phase == '0) begin
                    freq_d  = bus.freq_in;
                    phase_d = CNT_W'(BEAT_CYCLES - 1);
                    state_d = TONE;
                end
            end
            TONE: begin
                if (phase == '0) begin
                    phase_d = CNT_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (phase == '0) begin
                    if (slot != LAST_SLOT) begin
                        slot_d  = slot + SLOT_W'(1);
                        phase_d = CNT_W'(READ_LAT - 1);
                        state_d = SETTLE;
                    end else if (bus.loop_en) begin
                        slot_d  = '0;
                        phase_d = CNT_W'(READ_LAT - 1);
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every other transition.
        if (bus.stop && state != IDLE) begin
            state_d = IDLE;
            phase_d = '0;
        end

        playing_d   = (state_d != IDLE);
        step_done_d = (state_d == GAP) && (phase_d == '0);
        // Held off on the entry and exit edges so the wave starts and ends low.
        tone_en_c   = (state == TONE) && (state_d == TONE) && (freq_q != '0);
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .en          (tone_en_c),
        .half_period (freq_q),
        .wave        (audio_q)
    );

    assign bus.note_counter = slot;
    assign bus.ld_play      = playing_q;
    assign bus.playing      = playing_q;
    assign bus.step_done    = step_done_q;
    assign bus.audio_out    = audio_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Self-checking bench for playback_sequencer: elapsed-time reference model plus directed checks.
module tb_playback_sequencer;

    localparam int unsigned BEAT     = 20;
    localparam int unsigned GAPC     = 4;
    localparam int unsigned RLAT     = 3;
    localparam int unsigned SLOT_CYC = RLAT + BEAT + GAPC;
    localparam int unsigned TOTAL    = 16 * SLOT_CYC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    playback_sequencer_if bus ();

    playback_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAPC),
        .READ_LAT    (RLAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    // Note memory with a two-flop address path: data valid in the third cycle after an address change.
    logic [31:0] mem [16];
    logic [3:0]  addr_d1 = 4'd0;
    logic [3:0]  addr_d2 = 4'd0;
    always @(posedge clk) begin
        addr_d1 <= bus.note_counter;
        addr_d2 <= addr_d1;
    end
    assign bus.freq_in = mem[addr_d2];

    // Reference: playback is a function of cycles elapsed since the start edge.
    bit          m_active = 1'b0;
    int unsigned m_t      = 0;
    logic [3:0]  m_hold   = 4'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_hold   <= 4'd0;
        end else if (m_active) begin
            if (bus.stop) begin
                m_active <= 1'b0;
                m_hold   <= 4'(m_t / SLOT_CYC);
            end else if (m_t == TOTAL - 1) begin
                if (bus.loop_en) begin
                    m_t <= 0;
                end else begin
                    m_active <= 1'b0;
                    m_hold   <= 4'd15;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end else if (bus.start && !bus.stop) begin
            m_active <= 1'b1;
            m_t      <= 0;
        end
    end

    function automatic logic [3:0] exp_nc();
        return m_active ? 4'(m_t / SLOT_CYC) : m_hold;
    endfunction

    function automatic logic exp_step();
        return m_active && ((m_t % SLOT_CYC) == SLOT_CYC - 1);
    endfunction

    function automatic logic exp_audio();
        int unsigned w, k, f;
        if (!m_active) return 1'b0;
        w = m_t % SLOT_CYC;
        if (w < RLAT || w >= RLAT + BEAT) return 1'b0;
        f = mem[m_t / SLOT_CYC];
        if (f == 0) return 1'b0;
        k = w - RLAT;
        return ((k / f) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_note_counter", 32'(bus.note_counter), 32'(exp_nc()));
            check("model_playing",      32'(bus.playing),      32'(m_active));
            check("model_ld_play",      32'(bus.ld_play),      32'(m_active));
            check("model_step_done",    32'(bus.step_done),    32'(exp_step()));
            check("model_audio_out",    32'(bus.audio_out),    32'(exp_audio()));
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int   cyc, pulses, tog2, rest_high, rest_pulses;
    logic prev_audio;

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'(2 * i + 1);
        mem[4] = 32'd0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_on = 1'b1;
        check("reset_note_counter", 32'(bus.note_counter), 32'd0);
        check("reset_playing",      32'(bus.playing),      32'd0);
        check("reset_step_done",    32'(bus.step_done),    32'd0);
        check("reset_audio",        32'(bus.audio_out),    32'd0);
        @(negedge clk);

        // Single pass, no loop.
        pulse_start();
        check("start_playing", 32'(bus.playing), 32'd1);
        check("start_slot0",   32'(bus.note_counter), 32'd0);
        cyc = 0; pulses = 0; tog2 = 0; rest_high = 0; rest_pulses = 0;
        prev_audio = bus.audio_out;
        while (bus.playing && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (bus.step_done) begin
                pulses++;
                if (bus.note_counter == 4'd4) rest_pulses++;
            end
            if (bus.note_counter == 4'd2 && bus.audio_out != prev_audio) tog2++;
            if (bus.note_counter == 4'd4 && bus.audio_out) rest_high++;
            prev_audio = bus.audio_out;
        end
        check("pass_length",       32'(cyc),              32'd432);
        check("step_done_count",   32'(pulses),           32'd16);
        check("end_slot_hold",     32'(bus.note_counter), 32'd15);
        check("slot2_toggles",     32'(tog2),             32'd4);
        check("rest_audio_high",   32'(rest_high),        32'd0);
        check("rest_step_done",    32'(rest_pulses),      32'd1);

        // Looping, then loop_en dropped mid second pass.
        bus.loop_en = 1'b1;
        pulse_start();
        repeat (432) @(negedge clk);
        check("loop_wrap_slot",    32'(bus.note_counter), 32'd0);
        check("loop_wrap_playing", 32'(bus.playing),      32'd1);
        check("loop_wrap_audio",   32'(bus.audio_out),    32'd0);
        repeat (100) @(negedge clk);
        bus.loop_en = 1'b0;
        cyc = 532;
        while (bus.playing && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("loop_end_cycle", 32'(cyc), 32'd864);

        // start while playing is ignored; stop mid-TONE aborts.
        pulse_start();
        repeat (60) @(negedge clk);
        pulse_start();
        check("restart_ignored_slot", 32'(bus.note_counter), 32'd2);
        repeat (31) @(negedge clk);
        check("slot3_tone_audio", 32'(bus.audio_out), 32'd1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_playing", 32'(bus.playing),      32'd0);
        check("stop_ld_play", 32'(bus.ld_play),      32'd0);
        check("stop_audio",   32'(bus.audio_out),    32'd0);
        check("stop_slot",    32'(bus.note_counter), 32'd3);
        repeat (30) @(negedge clk);
        check("stop_stays_idle", 32'(bus.playing), 32'd0);

        // start and stop together in IDLE.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_idle", 32'(bus.playing), 32'd0);
        repeat (5) @(negedge clk);
        check("start_stop_idle_later", 32'(bus.playing), 32'd0);

        // Reset during slot 7 TONE, then a fresh start.
        pulse_start();
        repeat (200) @(negedge clk);
        check("slot7_reached", 32'(bus.note_counter), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_slot",      32'(bus.note_counter), 32'd0);
        check("midreset_playing",   32'(bus.playing),      32'd0);
        check("midreset_ld_play",   32'(bus.ld_play),      32'd0);
        check("midreset_step_done", 32'(bus.step_done),    32'd0);
        check("midreset_audio",     32'(bus.audio_out),    32'd0);
        repeat (2) @(negedge clk);
        pulse_start();
        check("after_reset_slot",    32'(bus.note_counter), 32'd0);
        check("after_reset_playing", 32'(bus.playing),      32'd1);
        repeat (40) @(negedge clk);
        check("after_reset_slot1", 32'(bus.note_counter), 32'd1);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
